// File: rtl/double_trouble.sv
// double_trouble: four-input "at least THRESHOLD of four" voter.
//
// Computes the popcount of {d,c,b,a} and compares it against THRESHOLD
// combinationally, and keeps a registered copy of the vote for synchronous
// consumers. There is no handshake: the vote is sampled on every rising
// edge of clk.
//
// Optional feature (macro DOUBLE_TROUBLE_HIT_CNT_EN): a saturating counter
// of clk edges that sampled out=1. It is cleared only by rst_n. With the
// macro undefined, the hit_cnt port and its register do not exist.
//
// Parameters:
//   THRESHOLD  minimum number of asserted inputs for out=1 (0..4)
//   CNT_W      width of the optional hit counter (1..32)
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   a,b,c,d  in   vote inputs 0..3
//   out      out  combinational vote, (count >= THRESHOLD)
//   count    out  combinational popcount of {d,c,b,a}, 0..4
//   out_q    out  out registered on clk
//   hit_cnt  out  saturating count of edges that sampled out=1 (macro only)

module double_trouble #(
    parameter int THRESHOLD = 2,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    output logic             out,
    output logic [2:0]       count,
`ifdef DOUBLE_TROUBLE_HIT_CNT_EN
    output logic             out_q,
    output logic [CNT_W-1:0] hit_cnt
`else
    output logic             out_q
`endif
);

    localparam logic [2:0] THR = 3'(THRESHOLD);

    logic out_q_q;
    logic out_q_d;

    // Zero-extend each input before adding so the sum cannot overflow.
    assign count = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};

    // A zero threshold is always met; tie it off explicitly rather than
    // relying on a comparison that is constant by construction.
    generate
        if (THRESHOLD == 0) begin : g_thr_zero
            assign out = 1'b1;
        end else begin : g_thr_cmp
            assign out = (count >= THR);
        end
    endgenerate

    assign out_q_d = out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q_q <= 1'b0;
        end else begin
            out_q_q <= out_q_d;
        end
    end

    assign out_q = out_q_q;

`ifdef DOUBLE_TROUBLE_HIT_CNT_EN
    logic [CNT_W-1:0] hit_cnt_q;
    logic [CNT_W-1:0] hit_cnt_d;

    // Saturate at all-ones instead of wrapping.
    always_comb begin
        hit_cnt_d = hit_cnt_q;
        if (out && (hit_cnt_q != {CNT_W{1'b1}})) begin
            hit_cnt_d = hit_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q <= '0;
        end else begin
            hit_cnt_q <= hit_cnt_d;
        end
    end

    assign hit_cnt = hit_cnt_q;
`endif

endmodule

// File: tb/tb_double_trouble.sv
// Scoreboard bench for double_trouble. Stimulus pushes expected values into
// a queue and fires an event; a separate monitor pops and compares against
// the DUT outputs. Three voters share the inputs (THRESHOLD 2, 4 and 0);
// with DOUBLE_TROUBLE_HIT_CNT_EN defined a fourth (CNT_W=2) checks hit_cnt.

module tb_double_trouble;

    typedef enum int {K_OUT2, K_CNT, K_OUTQ, K_OUT4, K_OUT0, K_HIT, K_OUT2_Q} kind_t;

    typedef struct {
        kind_t      kind;
        logic [7:0] exp;
        string      name;
    } exp_t;

    logic clk;
    logic clk_en;
    logic rst_n;
    logic a, b, c, d;

    logic       out2, out4, out0;
    logic [2:0] cnt2, cnt4, cnt0;
    logic       outq2, outq4, outq0;

    exp_t q[$];
    event chk_ev;
    int   checks;
    int   errors;

    double_trouble #(.THRESHOLD(2)) u_t2 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
        .out(out2), .count(cnt2),
`ifdef DOUBLE_TROUBLE_HIT_CNT_EN
        .out_q(outq2), .hit_cnt()
`else
        .out_q(outq2)
`endif
    );

    double_trouble #(.THRESHOLD(4)) u_t4 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
        .out(out4), .count(cnt4),
`ifdef DOUBLE_TROUBLE_HIT_CNT_EN
        .out_q(outq4), .hit_cnt()
`else
        .out_q(outq4)
`endif
    );

    double_trouble #(.THRESHOLD(0)) u_t0 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
        .out(out0), .count(cnt0),
`ifdef DOUBLE_TROUBLE_HIT_CNT_EN
        .out_q(outq0), .hit_cnt()
`else
        .out_q(outq0)
`endif
    );

`ifdef DOUBLE_TROUBLE_HIT_CNT_EN
    logic       outh;
    logic [2:0] cnth;
    logic       outqh;
    logic [1:0] hith;

    double_trouble #(.THRESHOLD(2), .CNT_W(2)) u_hc (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
        .out(outh), .count(cnth), .out_q(outqh), .hit_cnt(hith)
    );
`endif

    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    // Monitor: drains the scoreboard whenever stimulus signals a check point.
    initial begin
        exp_t       e;
        logic [7:0] act;
        forever begin
            @(chk_ev);
            while (q.size() > 0) begin
                e = q.pop_front();
                act = 8'h00;
                case (e.kind)
                    K_OUT2:   act = {7'd0, out2};
                    K_CNT:    act = {5'd0, cnt2};
                    K_OUTQ:   act = {7'd0, outq2};
                    K_OUT4:   act = {7'd0, out4};
                    K_OUT0:   act = {7'd0, out0};
`ifdef DOUBLE_TROUBLE_HIT_CNT_EN
                    K_HIT:    act = {6'd0, hith};
`endif
                    default:  act = 8'hxx;
                endcase
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s got %0h expected %0h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic push(input kind_t k, input logic [7:0] v, input string n);
        exp_t e;
        e.kind = k;
        e.exp  = v;
        e.name = n;
        q.push_back(e);
    endtask

    task automatic fire();
        -> chk_ev;
        #0;
    endtask

    task automatic set_in(input logic [3:0] v);
        {d, c, b, a} = v;
    endtask

    initial begin
        logic [15:0] mask2;
        logic [15:0] mask4;
        logic [15:0] mask0;
        logic [3:0]  code;
        logic [2:0]  pc;

        // Hand-derived truth tables, bit i = expected out for {d,c,b,a}=i.
        mask2 = 16'hFEE8;
        mask4 = 16'h8000;
        mask0 = 16'hFFFF;
        checks = 0;
        errors = 0;

        clk_en = 1'b0;
        rst_n  = 1'b0;
        set_in(4'b0000);
        #5;
        push(K_OUTQ, 8'd0, "reset_out_q");
`ifdef DOUBLE_TROUBLE_HIT_CNT_EN
        push(K_HIT, 8'd0, "reset_hit_cnt");
`endif
        fire();

        // Exhaustive sweep with no clock running.
        for (int i = 0; i < 16; i++) begin
            code = 4'(i);
            set_in(code);
            #5;
            pc = 3'(code[0]) + 3'(code[1]) + 3'(code[2]) + 3'(code[3]);
            push(K_OUT2, {7'd0, mask2[i]}, $sformatf("sweep_out_t2_%b", code));
            push(K_CNT,  {5'd0, pc},       $sformatf("sweep_count_%b", code));
            push(K_OUT4, {7'd0, mask4[i]}, $sformatf("sweep_out_t4_%b", code));
            push(K_OUT0, {7'd0, mask0[i]}, $sformatf("sweep_out_t0_%b", code));
            fire();
            #5;
        end

        // Start the clock, release reset between edges.
        set_in(4'b0011);
        clk_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push(K_OUTQ, 8'd1, "first_capture_out_q");
        fire();
        @(posedge clk);

        // Mid-run reset with a=b=1: out_q clears at once, out stays 1.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        push(K_OUTQ, 8'd0, "midrun_reset_out_q");
        push(K_OUT2, 8'd1, "midrun_reset_out");
        fire();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push(K_OUTQ, 8'd1, "post_release_out_q");
        fire();

        // Latency: 0001 then 0011 between edges.
        @(negedge clk);
        set_in(4'b0001);
        @(posedge clk);
        #1;
        push(K_OUTQ, 8'd0, "lat_hold_0001_out_q");
        fire();
        @(negedge clk);
        set_in(4'b0011);
        #1;
        push(K_OUT2, 8'd1, "lat_switch_out");
        push(K_OUTQ, 8'd0, "lat_switch_out_q_still0");
        fire();
        @(posedge clk);
        #1;
        push(K_OUTQ, 8'd1, "lat_next_edge_out_q");
        fire();

`ifdef DOUBLE_TROUBLE_HIT_CNT_EN
        // Saturating hit counter, CNT_W=2.
        @(negedge clk);
        rst_n = 1'b0;
        set_in(4'b1100);
        #1;
        push(K_HIT, 8'd0, "hit_pre_reset");
        fire();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            push(K_HIT, 8'((k > 3) ? 3 : k), $sformatf("hit_edge_%0d", k));
            fire();
        end
        @(negedge clk);
        set_in(4'b0000);
        for (int k = 1; k <= 2; k++) begin
            @(posedge clk);
            #1;
            push(K_HIT, 8'd3, $sformatf("hit_hold_idle_%0d", k));
            fire();
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        push(K_HIT, 8'd0, "hit_reset_clear");
        fire();
        @(negedge clk);
        rst_n = 1'b1;
`endif

        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d expected 0", q.size());
        end

        clk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
